mem_port_arbiter: RTL

- Shares the single unified instruction/data memory port of the multicycle MIPS core between two requesters: the core (fetch and lw/sw) and a program loader/debug port.
- Sits between the core's memory interface (driven by the IorD-selected address and the MemWrite enable) and the memory model.
- Handles variable memory latency with a ready handshake, round-robin arbitration, a watchdog timeout, and per-requester stall/acknowledge.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arbiter2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_CORE,
        REQ_LDR
    } requester_t;

    localparam int unsigned MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way requester pick: round-robin against last_grant, or loader-wins when FIXED_PRIO != 0.
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  requester_t last_grant,
    output logic       valid,
    output requester_t grant
);

    always_comb begin
        valid = |req;
        grant = REQ_CORE;
        case (req)
            2'b01:   grant = REQ_CORE;
            2'b10:   grant = REQ_LDR;
            2'b11: begin
                if (FIXED_PRIO != 0) begin
                    grant = REQ_LDR;
                end else begin
                    grant = (last_grant == REQ_LDR) ? REQ_CORE : REQ_LDR;
                end
            end
            default: grant = REQ_CORE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core and the loader with a ready handshake and a
// watchdog that aborts an access after TIMEOUT cycles without mem_ready_i.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TIMEOUT    = MEM_TIMEOUT_DEF,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_ack_o,
    output logic          core_stall_o,
    input  logic          ldr_req_i,
    input  logic          ldr_we_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic [DW-1:0] ldr_rdata_o,
    output logic          ldr_ack_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i
);

    localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    arb_state_t    state_q, state_d;
    requester_t    last_q, last_d;
    requester_t    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          core_ack_q, core_ack_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          err_q, err_d;

    logic          pick_valid;
    requester_t    pick;
    logic          finish;
    logic [DW-1:0] finish_data;

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req       ({ldr_req_i, core_req_i}),
        .last_grant(last_q),
        .valid     (pick_valid),
        .grant     (pick)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // Response outputs are single-cycle: zero unless set below.
        core_ack_d   = 1'b0;
        ldr_ack_d    = 1'b0;
        core_rdata_d = '0;
        ldr_rdata_d  = '0;
        err_d        = 1'b0;
        finish       = 1'b0;
        finish_data  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = MEM;
                    owner_d   = pick;
                    last_d    = pick;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (pick == REQ_LDR) begin
                        mem_we_d    = ldr_we_i;
                        mem_addr_d  = ldr_addr_i;
                        mem_wdata_d = ldr_wdata_i;
                    end else begin
                        mem_we_d    = core_we_i;
                        mem_addr_d  = core_addr_i;
                        mem_wdata_d = core_wdata_i;
                    end
                end
            end
            MEM: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Ready has priority over the watchdog in the same cycle.
                if (mem_ready_i) begin
                    finish      = 1'b1;
                    finish_data = mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
                if (finish) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q == REQ_LDR) begin
                        ldr_ack_d   = 1'b1;
                        ldr_rdata_d = finish_data;
                    end else begin
                        core_ack_d   = 1'b1;
                        core_rdata_d = finish_data;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            last_q       <= REQ_LDR;
            owner_q      <= REQ_CORE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_ack_q   <= 1'b0;
            ldr_ack_q    <= 1'b0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_ack_q   <= core_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
            err_q        <= err_d;
        end
    end

    assign core_rdata_o = core_rdata_q;
    assign core_ack_o   = core_ack_q;
    assign core_stall_o = core_req_i & ~core_ack_q;
    assign ldr_rdata_o  = ldr_rdata_q;
    assign ldr_ack_o    = ldr_ack_q;
    assign err_o        = err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
